// File: rtl/sram_responder_if.sv
// Control side of the SLC-3 external SRAM bus: active-low strobes plus the 20-bit word address.
// The 16-bit shared Data bus is a separate inout on the responder.
interface sram_responder_if;
    logic        CE;
    logic        UB;
    logic        LB;
    logic        OE;
    logic        WE;
    logic [19:0] ADDR;

    modport master (output CE, UB, LB, OE, WE, ADDR);
    modport slave  (input  CE, UB, LB, OE, WE, ADDR);
endinterface

// File: rtl/sram_responder.sv
// On-chip stand-in for the SLC-3 external SRAM: byte-lane writes, 1-cycle registered reads on Data.
// Define SRAM_RESP_CLEAR_EN to refill the array with INIT_VAL after every reset (Busy high meanwhile).
module sram_responder #(
    parameter int          ADDR_W   = 10,
    parameter logic [15:0] INIT_VAL = 16'h0000
) (
    input  logic             Clk,
    input  logic             Reset,
    sram_responder_if.slave  bus,
    inout  wire  [15:0]      Data,
    output logic             Busy,
    output logic [15:0]      Wr_count,
    output logic             dbg_state
);
    localparam int DEPTH = 1 << ADDR_W;

    // Bus protocol: a cycle is sampled at each rising edge while Busy=0 and CE=0.
    // WE=0 is a write (Data sampled at that edge); otherwise OE=0 is a read whose data
    // appears on Data after that edge and is released one edge after the request drops.
    logic [15:0]       mem [DEPTH];
    logic [15:0]       rdata;
    logic              drv;
    logic              drv_ub;
    logic              drv_lb;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              wr_cyc;
    logic              rd_cyc;
    logic              wr_count_en;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_idx;

    assign idx         = bus.ADDR[ADDR_W-1:0];
    assign in_range    = (bus.ADDR >> ADDR_W) == 20'd0;
    assign wr_cyc      = !Busy && !bus.CE && !bus.WE;
    assign rd_cyc      = !Busy && !bus.CE && !bus.OE && bus.WE;
    assign wr_count_en = wr_cyc && in_range && !(bus.UB && bus.LB);

`ifdef SRAM_RESP_CLEAR_EN
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    // Busy follows the state one edge late, so it falls the edge after the last word is written.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= CLEAR;
            ptr   <= '0;
            Busy  <= 1'b1;
        end else begin
            Busy <= (state == CLEAR);
            if (state == CLEAR) begin
                ptr <= ptr + 1'b1;
                if (ptr == '1) begin
                    state <= IDLE;
                end
            end
        end
    end

    assign sweep_we  = (state == CLEAR);
    assign sweep_idx = ptr;
    assign dbg_state = state;
`else
    assign Busy      = 1'b0;
    assign sweep_we  = 1'b0;
    assign sweep_idx = '0;
    assign dbg_state = 1'b0;
`endif

    // Array has no reset: contents survive Reset unless the clear sweep is built in.
    always_ff @(posedge Clk) begin
        if (sweep_we) begin
            mem[sweep_idx] <= INIT_VAL;
        end else if (wr_cyc && in_range) begin
            if (!bus.UB) begin
                mem[idx][15:8] <= Data[15:8];
            end
            if (!bus.LB) begin
                mem[idx][7:0] <= Data[7:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            drv    <= 1'b0;
            drv_ub <= 1'b0;
            drv_lb <= 1'b0;
            rdata  <= 16'h0000;
        end else begin
            drv <= rd_cyc;
            if (rd_cyc) begin
                rdata  <= in_range ? mem[idx] : 16'h0000;
                drv_ub <= !bus.UB;
                drv_lb <= !bus.LB;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Wr_count <= 16'h0000;
        end else if (wr_count_en) begin
            Wr_count <= Wr_count + 16'h0001;
        end
    end

    assign Data[15:8] = (drv && drv_ub) ? rdata[15:8] : 8'hzz;
    assign Data[7:0]  = (drv && drv_lb) ? rdata[7:0]  : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed vector table, hand-written corner sequences and a random
// phase checked against a word-map model; a pullup on Data makes an undriven lane read as FF.
module tb_sram_responder;
    localparam int          ADDR_W   = 10;
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [15:0] INIT_VAL = 16'h0000;
`ifdef SRAM_RESP_CLEAR_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] wr_count;
    logic        dbg_state;
    wire  [15:0] data;
    logic        tb_drv;
    logic [15:0] tb_data;
    int          errors = 0;
    int          checks = 0;

    sram_responder_if bus();

    assign data = tb_drv ? tb_data : 16'hzzzz;
    pullup (data);

    sram_responder #(.ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL)) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .bus      (bus),
        .Data     (data),
        .Busy     (busy),
        .Wr_count (wr_count),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];
    int unsigned ref_cnt = 0;

    function automatic bit model_in_range(logic [19:0] a);
        return a < 20'(DEPTH);
    endfunction

    function automatic void model_write(logic [19:0] a, logic [15:0] d, logic ub_n, logic lb_n);
        logic [15:0] w;
        if (!model_in_range(a) || (ub_n && lb_n)) return;
        w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : INIT_VAL;
        if (!ub_n) w[15:8] = d[15:8];
        if (!lb_n) w[7:0]  = d[7:0];
        ref_mem[int'(a)] = w;
        ref_cnt = (ref_cnt + 1) % 65536;
    endfunction

    // Expected bus value one cycle after a read request; disabled lanes float to FF.
    function automatic logic [15:0] model_read(logic [19:0] a, logic ub_n, logic lb_n);
        logic [15:0] w = 16'h0000;
        if (model_in_range(a)) w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : INIT_VAL;
        return {ub_n ? 8'hFF : w[15:8], lb_n ? 8'hFF : w[7:0]};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
        bus.UB = 1'b1; bus.LB = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub_n, input logic lb_n, input logic oe_n);
        bus.ADDR = a; bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = oe_n;
        bus.UB = ub_n; bus.LB = lb_n;
        tb_drv = 1'b1; tb_data = d;
        cyc();
        model_write(a, d, ub_n, lb_n);
        idle();
    endtask

    task automatic read_check(input string name, input logic [19:0] a,
                              input logic ub_n, input logic lb_n, input logic [15:0] exp);
        bus.ADDR = a; bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1;
        bus.UB = ub_n; bus.LB = lb_n; tb_drv = 1'b0;
        cyc();
        check(name, data, exp);
        idle();
        cyc();
        check({name, "_release"}, data, 16'hFFFF);
    endtask

    task automatic wait_sweep();
`ifdef SRAM_RESP_CLEAR_EN
        int n = 0;
        bit z_ok = 1'b1;
        bus.ADDR = 20'h0; bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1;
        bus.UB = 1'b0; bus.LB = 1'b0;
        while (busy === 1'b1 && n < 4 * DEPTH) begin
            if (data !== 16'hFFFF) z_ok = 1'b0;
            cyc();
            n++;
        end
        check("sweep_len", 16'(n), 16'(DEPTH + 1));
        check("sweep_bus_z", {15'd0, z_ok}, 16'd1);
        idle();
        ref_mem.delete();
        read_check("sweep_rd_first", 20'h00000, 1'b0, 1'b0, INIT_VAL);
        read_check("sweep_rd_last", 20'(DEPTH - 1), 1'b0, 1'b0, INIT_VAL);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_rd;
        bit          oe_n;
        logic [19:0] addr;
        logic [15:0] d;
        bit          ub_n;
        bit          lb_n;
        logic [15:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{0, 1, 20'h00012, 16'h005A, 0, 0, 16'h0000, 16'd1};
        vecs[1]  = '{1, 0, 20'h00012, 16'h0000, 0, 0, 16'h005A, 16'd1};
        vecs[2]  = '{0, 1, 20'h00003, 16'hBEEF, 0, 0, 16'h0000, 16'd2};
        vecs[3]  = '{0, 1, 20'h00003, 16'h1234, 0, 1, 16'h0000, 16'd3};
        vecs[4]  = '{1, 0, 20'h00003, 16'h0000, 0, 0, 16'h12EF, 16'd3};
        vecs[5]  = '{1, 0, 20'h00003, 16'h0000, 1, 0, 16'hFFEF, 16'd3};
        vecs[6]  = '{0, 0, 20'h00004, 16'hA5A5, 0, 0, 16'h0000, 16'd4};
        vecs[7]  = '{1, 0, 20'h00004, 16'h0000, 0, 0, 16'hA5A5, 16'd4};
        vecs[8]  = '{0, 1, 20'h80000, 16'h1111, 0, 0, 16'h0000, 16'd4};
        vecs[9]  = '{1, 0, 20'h80000, 16'h0000, 0, 0, 16'h0000, 16'd4};
        vecs[10] = '{0, 1, 20'h00020, 16'h7777, 1, 1, 16'h0000, 16'd4};
        vecs[11] = '{1, 0, 20'h00012, 16'h0000, 0, 1, 16'h00FF, 16'd4};
        vecs[12] = '{1, 0, 20'h00012, 16'h0000, 1, 1, 16'hFFFF, 16'd4};
        vecs[13] = '{0, 1, 20'h003FF, 16'hDEAD, 0, 0, 16'h0000, 16'd5};
        vecs[14] = '{1, 0, 20'h003FF, 16'h0000, 0, 0, 16'hDEAD, 16'd5};
        vecs[15] = '{1, 0, 20'h00400, 16'h0000, 0, 0, 16'h0000, 16'd5};
        vecs[16] = '{0, 1, 20'h00400, 16'hCAFE, 0, 0, 16'h0000, 16'd5};

        // Reset state
        rst_n = 1'b0;
        idle();
        bus.ADDR = 20'h0;
        tb_data = 16'h0000;
        #1;
        check("rst_busy", 16'(busy), 16'(RST_BUSY));
        check("rst_wr_count", wr_count, 16'h0000);
        check("rst_data_z", data, 16'hFFFF);
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_sweep();
        check("busy_low", 16'(busy), 16'h0000);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_rd) begin
                read_check($sformatf("vec%0d_data", i), vecs[i].addr,
                           vecs[i].ub_n, vecs[i].lb_n, vecs[i].exp_data);
            end else begin
                do_write(vecs[i].addr, vecs[i].d, vecs[i].ub_n, vecs[i].lb_n, vecs[i].oe_n);
                #1;
                check($sformatf("vec%0d_bus_free", i), data, 16'hFFFF);
            end
            check($sformatf("vec%0d_count", i), wr_count, vecs[i].exp_cnt);
        end

        // Read on the edge right after a write to the same address
        do_write(20'h00030, 16'h1357, 1'b0, 1'b0, 1'b1);
        read_check("raw_same_addr", 20'h00030, 1'b0, 1'b0, 16'h1357);

        // Held read tracks ADDR with one cycle of lag
        do_write(20'h00040, 16'h1111, 1'b0, 1'b0, 1'b1);
        do_write(20'h00041, 16'h2222, 1'b0, 1'b0, 1'b1);
        do_write(20'h00042, 16'h3333, 1'b0, 1'b0, 1'b1);
        bus.ADDR = 20'h00040; bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1;
        bus.UB = 1'b0; bus.LB = 1'b0;
        cyc();
        check("held_0", data, 16'h1111);
        bus.ADDR = 20'h00041;
        #1;
        check("held_lag", data, 16'h1111);
        cyc();
        check("held_1", data, 16'h2222);
        bus.ADDR = 20'h00042;
        cyc();
        check("held_2", data, 16'h3333);
        bus.OE = 1'b1;
        cyc();
        check("held_oe_release", data, 16'hFFFF);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 8; i++) begin
            do_write(20'(256 + i), 16'($urandom), 1'b0, 1'b0, 1'b1);
        end
        for (int it = 0; it < 250; it++) begin
            logic [19:0] a;
            logic [15:0] d;
            logic        ub_n;
            logic        lb_n;
            int          op;
            if ($urandom_range(0, 9) == 0) a = 20'($urandom_range(DEPTH, 20'hFFFFF));
            else                           a = 20'(256 + $urandom_range(0, 7));
            d    = 16'($urandom);
            ub_n = 1'($urandom_range(0, 1));
            lb_n = 1'($urandom_range(0, 1));
            op   = $urandom_range(0, 9);
            if (op < 5) begin
                do_write(a, d, ub_n, lb_n, 1'b1);
            end else if (op < 9) begin
                read_check("rnd_read", a, ub_n, lb_n, model_read(a, ub_n, lb_n));
            end else begin
                do_write(a, d, ub_n, lb_n, 1'b0);
                #1;
                check("rnd_we_oe_bus_free", data, 16'hFFFF);
            end
            check("rnd_count", wr_count, 16'(ref_cnt));
        end
        for (int i = 0; i < 8; i++) begin
            read_check("rnd_final", 20'(256 + i), 1'b0, 1'b0, model_read(20'(256 + i), 1'b0, 1'b0));
        end

        // Counter wrap: hold a write until the count reaches FFFF, then one more
        begin
            int unsigned k;
            k = 65535 - ref_cnt;
            bus.ADDR = 20'h00050; bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b1;
            bus.UB = 1'b0; bus.LB = 1'b0; tb_drv = 1'b1; tb_data = 16'h0F0F;
            repeat (k) begin
                cyc();
                model_write(20'h00050, 16'h0F0F, 1'b0, 1'b0);
            end
            check("wrap_ffff", wr_count, 16'(ref_cnt));
            check("wrap_ffff_abs", wr_count, 16'hFFFF);
            cyc();
            model_write(20'h00050, 16'h0F0F, 1'b0, 1'b0);
            check("wrap_zero", wr_count, 16'(ref_cnt));
            idle();
        end
        read_check("wrap_data", 20'h00050, 1'b0, 1'b0, 16'h0F0F);

        // Reset asserted in the middle of a held read
        do_write(20'h00060, 16'h6060, 1'b0, 1'b0, 1'b1);
        bus.ADDR = 20'h00060; bus.CE = 1'b0; bus.OE = 1'b0; bus.WE = 1'b1;
        bus.UB = 1'b0; bus.LB = 1'b0;
        cyc();
        check("pre_reset_read", data, 16'h6060);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_z", data, 16'hFFFF);
        check("reset_async_count", wr_count, 16'h0000);
        check("reset_busy", 16'(busy), 16'(RST_BUSY));
        ref_cnt = 0;
        idle();
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_sweep();
        read_check("after_reset_read", 20'h00060, 1'b0, 1'b0, model_read(20'h00060, 1'b0, 1'b0));
        do_write(20'h00061, 16'h4242, 1'b0, 1'b0, 1'b1);
        check("after_reset_count", wr_count, 16'(ref_cnt));
        read_check("after_reset_write", 20'h00061, 1'b0, 1'b0, 16'h4242);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the SLC-3 external SRAM bus: the memory end of the CE/UB/LB/OE/WE/ADDR/Data interface that the CPU datapath drives as initiator. It sits beside `lab6_toplevel` in simulation and FPGA builds, replacing the physical SRAM with an on-chip word array. It accepts byte-lane writes, returns registered read data on the shared tri-state `Data` bus, and counts completed writes. It optionally clears its contents after reset.

## Interface
- `ADDR_W`, 10, implemented address bits; array depth is 2^ADDR_W 16-bit words.
- `INIT_VAL`, 16'h0000, word written by the post-reset clear sweep.

- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `CE`  in  1  chip enable, active-low.
- `UB`  in  1  upper byte lane `[15:8]` enable, active-low.
- `LB`  in  1  lower byte lane `[7:0]` enable, active-low.
- `OE`  in  1  output enable, active-low.
- `WE`  in  1  write enable, active-low.
- `ADDR`  in  20  word address.
- `Data`  inout  16  shared data bus; driven only during reads, otherwise high-Z.
- `Busy`  out  1  clear sweep in progress; bus ignored while high.
- `Wr_count`  out  16  number of completed write cycles.

## Operation
- In range: `ADDR[19:ADDR_W]` == 0. Out-of-range writes are dropped and not counted. Out-of-range reads return 16'h0000.
- Write: at an edge where `Busy`=0, `CE`=0 and `WE`=0, bytes from `Data` are stored to `mem[ADDR]` for each enabled lane.
  - `UB`=0 stores `[15:8]`; `LB`=0 stores `[7:0]`.
  - If at least one lane is enabled and the address is in range, `Wr_count` increments. It wraps from FFFF to 0000.
  - With both lanes disabled, there is no store and no count.
- Read request: at an edge where `Busy`=0, `CE`=0, `OE`=0 and `WE`=1:
  - `rdata` <= `mem[ADDR]`.
  - `drv` <= 1.
  - `drv_ub` <= !`UB`, `drv_lb` <= !`LB`.
- At any other edge, `drv` <= 0.
- Bus drive: `Data[15:8]` = `drv & drv_ub` ? `rdata[15:8]` : Z. `Data[7:0]` is driven the same way using `drv_lb`.
- WE beats OE: if both are low, the cycle is a write and the bus is not driven.
- Read-after-write to the same address on consecutive edges returns the new data, because the array is written before the next read sample.
- State machine (only with `SRAM_RESP_CLEAR_EN`):
  - CLEAR: `ptr` counts 0..2^ADDR_W−1, writing `INIT_VAL` to one word per cycle; `Busy`=1.
  - After the last word, the FSM moves to IDLE; `Busy` falls on the following edge.
  - IDLE: normal bus service.
- Reset mid-operation: `drv` clears immediately and `Data` goes high-Z asynchronously. The clear sweep restarts from address 0. Memory is otherwise not reset.

## Timing
- Reset values:
  - `Data` = Z, `Busy` = 1 (macro) / 0 (no macro), `Wr_count` = 0.
  - `drv`, `drv_ub`, `drv_lb` = 0; `rdata` = 0; `ptr` = 0.
- Read latency is 1 cycle: data is valid on `Data` after the first rising edge that samples the request. It stays valid while the request is held and tracks `ADDR` with 1-cycle lag.
- Bus release is 1 cycle after `OE`, `CE` or `WE` deasserts (sampled at the next edge). The initiator must not drive `Data` in that cycle.
- Write takes effect at the sampling edge. `Wr_count` updates at that same edge.
- Clear sweep is 2^ADDR_W cycles from the first edge after `Reset` rises; `Busy` is low from cycle 2^ADDR_W + 1.

## Configuration
- `SRAM_RESP_CLEAR_EN` defined:
  - CLEAR state and `ptr` counter are present.
  - Every reset refills the array with `INIT_VAL`, and `Busy` behaves as above.
- Not defined:
  - No sweep; `Busy` is tied to 0.
  - Array contents are undefined at power-up and retained across `Reset`.
  - Bus service starts at the first edge after `Reset` rises.

## Test plan
- Reset low, then high, with macro and `ADDR_W`=10 → `Busy`=1 for 1024 cycles, then 0. Reads of 0x000 and 0x3FF return 16'h0000; `Data` is Z throughout the sweep.
- Write 16'h005A to 0x00012 with both lanes enabled, then read 0x00012 → `Data`=16'h005A one cycle after the read request; `Wr_count`=1.
- Write 16'hBEEF to 0x00003, then write 16'h1234 with only `UB`=0 → read gives 16'h12EF. With only `LB`=0 driving during the read, `Data[15:8]`=Z and `Data[7:0]`=16'hEF.
- `OE`=0 and `WE`=0 together at 0x00004 with initiator driving 16'hA5A5 → no contention, the word is stored, and a later read returns 16'hA5A5.
- Write to 0x80000 (out of range) → `Wr_count` unchanged; read of 0x80000 returns 16'h0000.
- Preload `Wr_count` to FFFF via 65535 writes, then one more write → `Wr_count`=0000. Assert `Reset` during a held read → `Data` goes Z immediately.
